// File: rtl/booth_pkg.sv
// Shared types and constants for the radix-4 Booth multiplier.
// Optional simulation checks in the top are enabled by defining BOOTH_ASSERT_EN.
package booth_pkg;

    localparam int OP_W   = 32;   // operand width
    localparam int PROD_W = 64;   // product width
    localparam int ACC_W  = 34;   // accumulator width: room for +/-2A plus carry
    localparam int STEPS  = 16;   // two multiplier bits retired per step
    localparam int CNT_W  = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    typedef enum logic [2:0] {
        ZERO = 3'd0,
        POS1 = 3'd1,
        POS2 = 3'd2,
        NEG1 = 3'd3,
        NEG2 = 3'd4
    } sel_e;

    // Map a {m[1], m[0], q(-1)} triplet to its Booth digit.
    function automatic sel_e booth_decode(input logic [2:0] trip);
        sel_e s;
        case (trip)
            3'b001, 3'b010: s = POS1;
            3'b011:         s = POS2;
            3'b100:         s = NEG2;
            3'b101, 3'b110: s = NEG1;
            default:        s = ZERO;   // 000 and 111
        endcase
        return s;
    endfunction

endpackage

// File: rtl/booth_radix4_encoder.sv
// Combinational radix-4 Booth partial-product generator: 0, +/-A, +/-2A at 34 bits.
module booth_radix4_encoder
    import booth_pkg::*;
(
    input  logic [2:0]       trip_i,
    input  logic [OP_W-1:0]  mcand_i,
    output logic [ACC_W-1:0] pp_o
);

    logic [ACC_W-1:0] a1;
    logic [ACC_W-1:0] a2;
    sel_e             sel;

    assign a1  = {{2{mcand_i[OP_W-1]}}, mcand_i};
    assign a2  = {mcand_i[OP_W-1], mcand_i, 1'b0};
    assign sel = booth_decode(trip_i);

    // Select the partial product; negation is two's complement (~X + 1).
    always_comb begin
        pp_o = '0;
        case (sel)
            POS1:    pp_o = a1;
            POS2:    pp_o = a2;
            NEG1:    pp_o = ~a1 + ACC_W'(1);
            NEG2:    pp_o = ~a2 + ACC_W'(1);
            default: pp_o = '0;
        endcase
    end

endmodule

// File: rtl/booth_multiplier_32.sv
// Sequential signed 32x32 radix-4 Booth multiplier, 16 steps per product.
// Define BOOTH_ASSERT_EN to compile simulation-only consistency checks.
module booth_multiplier_32
    import booth_pkg::*;
(
    input  logic              clk,
    input  logic              async_rst,
    input  logic              valid,
    input  logic [OP_W-1:0]   A,
    input  logic [OP_W-1:0]   B,
    output logic [PROD_W-1:0] R,
    output logic              ready
);

    state_e             state_q, state_d;
    logic [OP_W-1:0]    mcand_q;
    logic [OP_W-1:0]    mplr_q;
    logic [ACC_W-1:0]   acc_q;
    logic               qm1_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [PROD_W-1:0]  r_q;
    logic               ready_q;

    logic               load;
    logic               step;
    logic               finish;

    logic [ACC_W-1:0]   pp;
    logic [ACC_W-1:0]   sum;
    logic signed [ACC_W+OP_W:0] shift_w;
    logic [ACC_W-1:0]   acc_d;
    logic [OP_W-1:0]    mplr_d;
    logic               qm1_d;
    logic [PROD_W-1:0]  r_d;

    booth_radix4_encoder u_enc (
        .trip_i  ({mplr_q[1:0], qm1_q}),
        .mcand_i (mcand_q),
        .pp_o    (pp)
    );

    // Add the partial product, then shift {acc, m, q(-1)} right by two, sign-filled.
    assign sum     = acc_q + pp;
    assign shift_w = $signed({sum, mplr_q, qm1_q}) >>> 2;
    assign acc_d   = shift_w[ACC_W+OP_W:OP_W+1];
    assign mplr_d  = shift_w[OP_W:1];
    assign qm1_d   = shift_w[0];
    assign r_d     = {acc_d[OP_W-1:0], mplr_d};

    // State register.
    always_ff @(posedge clk or posedge async_rst) begin
        if (async_rst) state_q <= IDLE;
        else           state_q <= state_d;
    end

    // Next-state logic: valid only starts from IDLE/DONE; BUSY runs to completion.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, DONE: if (valid) state_d = BUSY;
            BUSY:       if (cnt_q == CNT_W'(STEPS - 1)) state_d = DONE;
            default:    state_d = IDLE;
        endcase
    end

    // Control decode for the datapath.
    always_comb begin
        load   = 1'b0;
        step   = 1'b0;
        finish = 1'b0;
        case (state_q)
            IDLE, DONE: load = valid;
            BUSY: begin
                step   = 1'b1;
                finish = (cnt_q == CNT_W'(STEPS - 1));
            end
            default: ;
        endcase
    end

    // Datapath: operand capture, iteration, and result latch on the last step.
    always_ff @(posedge clk or posedge async_rst) begin
        if (async_rst) begin
            mcand_q <= '0;
            mplr_q  <= '0;
            acc_q   <= '0;
            qm1_q   <= 1'b0;
            cnt_q   <= '0;
            r_q     <= '0;
            ready_q <= 1'b0;
        end else if (load) begin
            mcand_q <= A;
            mplr_q  <= B;
            acc_q   <= '0;
            qm1_q   <= 1'b0;
            cnt_q   <= '0;
            ready_q <= 1'b0;
        end else if (step) begin
            acc_q  <= acc_d;
            mplr_q <= mplr_d;
            qm1_q  <= qm1_d;
            cnt_q  <= cnt_q + CNT_W'(1);
            if (finish) begin
                r_q     <= r_d;
                ready_q <= 1'b1;
            end
        end
    end

    assign R     = r_q;
    assign ready = ready_q;

`ifdef BOOTH_ASSERT_EN
    logic [OP_W-1:0] chk_a_q, chk_b_q;

    // Shadow copy of the accepted operands for the completion check.
    always_ff @(posedge clk) begin
        if (load) begin
            chk_a_q <= A;
            chk_b_q <= B;
        end
    end

    // Operand sanity, ready/BUSY exclusion, and exact product at completion.
    always_ff @(posedge clk) begin
        if (!async_rst) begin
            if (load)
                assert (!$isunknown({A, B})) else $error("booth: X/Z operand at accept");
            assert (!(state_q == BUSY && ready_q)) else $error("booth: ready high in BUSY");
            if (finish)
                assert (r_d == PROD_W'($signed({{OP_W{chk_a_q[OP_W-1]}}, chk_a_q}) *
                                       $signed({{OP_W{chk_b_q[OP_W-1]}}, chk_b_q})))
                    else $error("booth: wrong product");
        end
    end
`endif

endmodule

// File: tb/tb_booth_multiplier_32.sv
// Self-checking bench for booth_multiplier_32: vector table, random operands
// against a plain-arithmetic model, and hand sequences for control corners.
module tb_booth_multiplier_32;

    logic        clk;
    logic        async_rst;
    logic        valid;
    logic [31:0] A, B;
    logic [63:0] R;
    logic        ready;

    int checks = 0;
    int errors = 0;

    booth_multiplier_32 dut (
        .clk       (clk),
        .async_rst (async_rst),
        .valid     (valid),
        .A         (A),
        .B         (B),
        .R         (R),
        .ready     (ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] r;
    } vec_t;

    function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b);
        longint sa, sb;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        return 64'(sa * sb);
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // One full transaction from an idle/done unit, with latency and hold checks.
    task automatic do_mul(input logic [31:0] a, input logic [31:0] b,
                          input logic [63:0] exp, input string nm);
        logic [63:0] prev;
        prev = R;
        @(negedge clk);
        A = a; B = b; valid = 1'b1;
        @(negedge clk);
        valid = 1'b0; A = $urandom; B = $urandom;
        chk({nm, "_ready_drop"}, {63'd0, ready}, 64'd0);
        for (int i = 1; i <= 16; i++) begin
            @(negedge clk);
            if (i == 8) begin
                chk({nm, "_busy_hold"}, R, prev);
                chk({nm, "_busy_ready"}, {63'd0, ready}, 64'd0);
            end
            if (i == 15) chk({nm, "_early"}, {63'd0, ready}, 64'd0);
        end
        chk({nm, "_ready"}, {63'd0, ready}, 64'd1);
        chk({nm, "_R"}, R, exp);
    endtask

    vec_t vecs[9];

    initial begin
        logic [31:0] ra, rb;
        logic [63:0] first_exp;

        async_rst = 1'b0; valid = 1'b0; A = '0; B = '0;

        // Reset asserted between edges takes effect without a clock.
        #2 async_rst = 1'b1;
        #1;
        chk("reset_R", R, 64'd0);
        chk("reset_ready", {63'd0, ready}, 64'd0);
        @(negedge clk);
        async_rst = 1'b0;

        vecs[0] = '{32'h12345678, 32'h00ABCDEF, model(32'h12345678, 32'h00ABCDEF)};
        vecs[1] = '{32'd7,        32'hFFFFFFFD, 64'hFFFFFFFF_FFFFFFEB};
        vecs[2] = '{32'h80000001, 32'd2,        64'hFFFFFFFF_00000002};
        vecs[3] = '{32'h80000000, 32'h80000000, 64'h40000000_00000000};
        vecs[4] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 64'h00000000_00000001};
        vecs[5] = '{32'h7FFFFFFF, 32'h7FFFFFFF, 64'h3FFFFFFF_00000001};
        vecs[6] = '{32'h80000000, 32'h7FFFFFFF, 64'hC0000000_80000000};
        vecs[7] = '{32'h80000000, 32'd1,        64'hFFFFFFFF_80000000};
        vecs[8] = '{32'd0,        32'hDEADBEEF, 64'd0};

        foreach (vecs[i]) do_mul(vecs[i].a, vecs[i].b, vecs[i].r, $sformatf("vec%0d", i));

        // Random operands, biased now and then toward the extremes.
        for (int n = 0; n < 30; n++) begin
            ra = $urandom;
            rb = $urandom;
            if (n % 7 == 0) ra = 32'h80000000;
            if (n % 5 == 0) rb = 32'hFFFFFFFF;
            do_mul(ra, rb, model(ra, rb), $sformatf("rnd%0d", n));
        end

        // valid held during BUSY with other operands is ignored.
        first_exp = model(32'h00001234, 32'hFFFF0001);
        @(negedge clk);
        A = 32'h00001234; B = 32'hFFFF0001; valid = 1'b1;
        @(negedge clk);
        valid = 1'b0;
        for (int i = 1; i <= 16; i++) begin
            @(negedge clk);
            if (i >= 3 && i <= 10) begin
                valid = 1'b1; A = $urandom; B = $urandom;
            end else begin
                valid = 1'b0;
            end
        end
        chk("ign_ready", {63'd0, ready}, 64'd1);
        chk("ign_R", R, first_exp);

        // valid at the first DONE edge restarts immediately (17-cycle throughput).
        A = 32'hFFFFFFF0; B = 32'h00000010; valid = 1'b1;
        @(negedge clk);
        valid = 1'b0;
        chk("b2b_ready_drop", {63'd0, ready}, 64'd0);
        chk("b2b_R_hold", R, first_exp);
        repeat (16) @(negedge clk);
        chk("b2b_ready", {63'd0, ready}, 64'd1);
        chk("b2b_R", R, model(32'hFFFFFFF0, 32'h00000010));

        // Async reset mid-BUSY aborts; unit stays idle until a fresh valid.
        A = 32'h0BADF00D; B = 32'h00C0FFEE; valid = 1'b1;
        @(negedge clk);
        valid = 1'b0;
        repeat (5) @(negedge clk);
        #1 async_rst = 1'b1;
        #1;
        chk("midrst_R", R, 64'd0);
        chk("midrst_ready", {63'd0, ready}, 64'd0);
        #1 async_rst = 1'b0;
        repeat (20) @(negedge clk);
        chk("midrst_idle_ready", {63'd0, ready}, 64'd0);
        chk("midrst_idle_R", R, 64'd0);
        do_mul(32'hFFFFFF85, 32'h0000007B, model(32'hFFFFFF85, 32'h0000007B), "post_rst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: timeout reached, expected completion before %0d", 200000);
        errors++;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
